// File: rtl/bypass_rsp_router_pkg.sv
// Shared configuration for the bypass response router: geometry, tag layout
// and the pending-read slot entry.
package bypass_rsp_router_pkg;

  localparam int NUM_REQS        = 4;
  localparam int CACHE_LINE_SIZE = 64;
  localparam int WORD_SIZE       = 4;
  localparam int CORE_TAG_WIDTH  = 3;
  localparam int DRAM_TAG_WIDTH  = 26;
  localparam int PENDING_SIZE    = 4;

  localparam int ID_W           = $clog2(PENDING_SIZE);
  localparam int LANE_W         = $clog2(NUM_REQS);
  localparam int WORDS_PER_LINE = CACHE_LINE_SIZE / WORD_SIZE;
  localparam int WORD_SEL_BITS  = $clog2(WORDS_PER_LINE);
  localparam int LINE_BITS      = CACHE_LINE_SIZE * 8;
  localparam int WORD_BITS      = WORD_SIZE * 8;
  localparam int BYPASS_TAG_BIT = DRAM_TAG_WIDTH - 1;
  localparam int PERF_W         = 44;

  // One outstanding bypass read: where its single word goes back to.
  typedef struct packed {
    logic                      valid;
    logic [LANE_W-1:0]         lane;
    logic [WORD_SEL_BITS-1:0]  wsel;
    logic [CORE_TAG_WIDTH-1:0] tag;
  } slot_t;

  // Lowest index whose busy bit is clear; 0 when everything is busy.
  function automatic logic [ID_W-1:0] lowest_free(input logic [PENDING_SIZE-1:0] busy);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/bypass_rsp_router_lane_reg.sv
// Single-entry valid/ready output register for one core lane. A new word may
// load in the same cycle the held word is taken.
module bypass_rsp_lane_reg
  import bypass_rsp_router_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_BITS-1:0]      in_data,
  input  logic [CORE_TAG_WIDTH-1:0] in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_BITS-1:0]      out_data,
  output logic [CORE_TAG_WIDTH-1:0] out_tag
);

  logic                      valid_q, valid_d;
  logic [WORD_BITS-1:0]      data_q, data_d;
  logic [CORE_TAG_WIDTH-1:0] tag_q, tag_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;

  // Next-state: drain on out_ready, load on an accepted input (load wins).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (out_ready) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      tag_d   = in_tag;
    end
  end

  // Register update; only the valid bit needs a reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: rtl/bypass_rsp_router.sv
// Bypass DRAM response router. Records outstanding bypass reads in a small
// slot table, turns bypass DRAM responses into single-word per-lane core
// responses, and passes every other response to the cache untouched.
// Optional performance counters are built when BYPASS_RSP_PERF_EN is defined.
module bypass_rsp_router
  import bypass_rsp_router_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     issue_valid,
  input  logic                                     issue_rw,
  input  logic [LANE_W-1:0]                        issue_lane,
  input  logic [WORD_SEL_BITS-1:0]                 issue_wsel,
  input  logic [CORE_TAG_WIDTH-1:0]                issue_tag,
  output logic                                     issue_ready,
  output logic [ID_W-1:0]                          issue_id,
  input  logic                                     dram_rsp_valid,
  input  logic [LINE_BITS-1:0]                     dram_rsp_data,
  input  logic [DRAM_TAG_WIDTH-1:0]                dram_rsp_tag,
  output logic                                     dram_rsp_ready,
  output logic                                     cache_rsp_valid,
  output logic [LINE_BITS-1:0]                     cache_rsp_data,
  output logic [DRAM_TAG_WIDTH-1:0]                cache_rsp_tag,
  input  logic                                     cache_rsp_ready,
  output logic [NUM_REQS-1:0]                      core_rsp_valid,
  output logic [NUM_REQS-1:0][WORD_BITS-1:0]       core_rsp_data,
  output logic [NUM_REQS-1:0][CORE_TAG_WIDTH-1:0]  core_rsp_tag,
  input  logic [NUM_REQS-1:0]                      core_rsp_ready,
  output logic                                     pending_empty,
`ifdef BYPASS_RSP_PERF_EN
  output logic [PERF_W-1:0]                        perf_bypass_reads,
  output logic [PERF_W-1:0]                        perf_bypass_stalls,
`endif
  output logic                                     err_unexpected
);

  slot_t                   slot_q [PENDING_SIZE];
  slot_t                   slot_d [PENDING_SIZE];
  logic [PENDING_SIZE-1:0] busy;
  logic                    full;
  logic                    issue_alloc;
  logic                    err_q, err_d;

  logic                                    is_bypass;
  logic [ID_W-1:0]                         rsp_id;
  slot_t                                   rsp_slot;
  logic                                    rsp_hit;
  logic                                    byp_fire;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] line_words;
  logic [WORD_BITS-1:0]                    rsp_word;
  logic [NUM_REQS-1:0]                     lane_in_valid;
  logic [NUM_REQS-1:0]                     lane_in_ready;

  genvar gi;

  // Busy vector gathered from the slot table.
  generate
    for (gi = 0; gi < PENDING_SIZE; gi++) begin : g_busy
      assign busy[gi] = slot_q[gi].valid;
    end
  endgenerate

  assign full          = &busy;
  assign pending_empty = ~|busy;
  assign issue_id      = lowest_free(busy);
  // Writes never occupy a slot, so they are never held back by a full table.
  assign issue_ready   = ~full | issue_rw;
  assign issue_alloc   = issue_valid & ~issue_rw & ~full;

  // Response decode: the tag MSB selects bypass, low bits name the slot.
  assign is_bypass  = dram_rsp_tag[BYPASS_TAG_BIT];
  assign rsp_id     = dram_rsp_tag[ID_W-1:0];
  assign rsp_slot   = slot_q[rsp_id];
  assign rsp_hit    = rsp_slot.valid;
  assign line_words = dram_rsp_data;
  assign rsp_word   = line_words[rsp_slot.wsel];

  // Passthrough is purely combinational; data and tag go out verbatim.
  assign cache_rsp_valid = dram_rsp_valid & ~is_bypass;
  assign cache_rsp_data  = dram_rsp_data;
  assign cache_rsp_tag   = dram_rsp_tag;

  // DRAM backpressure: only the target of the current response can stall it.
  // A bypass response for a free slot is always taken so it cannot wedge the port.
  always_comb begin
    dram_rsp_ready = cache_rsp_ready;
    if (is_bypass) begin
      dram_rsp_ready = rsp_hit ? lane_in_ready[rsp_slot.lane] : 1'b1;
    end
  end

  assign byp_fire = dram_rsp_valid & is_bypass & dram_rsp_ready;

  // Per-lane output registers; each lane drains independently.
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_lane
      assign lane_in_valid[gi] = byp_fire & rsp_hit & (rsp_slot.lane == LANE_W'(gi));

      bypass_rsp_lane_reg u_lane (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (lane_in_valid[gi]),
        .in_ready  (lane_in_ready[gi]),
        .in_data   (rsp_word),
        .in_tag    (rsp_slot.tag),
        .out_valid (core_rsp_valid[gi]),
        .out_ready (core_rsp_ready[gi]),
        .out_data  (core_rsp_data[gi]),
        .out_tag   (core_rsp_tag[gi])
      );
    end
  endgenerate

  // Slot table next state: free the answered slot, record a new read.
  // The freed slot is never the allocated one because issue_id was taken
  // from the current (pre-free) busy vector.
  always_comb begin
    slot_d = slot_q;
    err_d  = err_q;
    if (byp_fire) begin
      if (rsp_hit) slot_d[rsp_id].valid = 1'b0;
      else         err_d = 1'b1;
    end
    if (issue_alloc) begin
      slot_d[issue_id].valid = 1'b1;
      slot_d[issue_id].lane  = issue_lane;
      slot_d[issue_id].wsel  = issue_wsel;
      slot_d[issue_id].tag   = issue_tag;
    end
  end

  // Slot table and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PENDING_SIZE; i++) slot_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < PENDING_SIZE; i++) slot_q[i] <= slot_d[i];
      err_q <= err_d;
    end
  end

  assign err_unexpected = err_q;

`ifdef BYPASS_RSP_PERF_EN
  logic [PERF_W-1:0] reads_q, reads_d;
  logic [PERF_W-1:0] stalls_q, stalls_d;

  // Counter increments; both wrap naturally at the counter width.
  always_comb begin
    reads_d  = reads_q + PERF_W'(issue_alloc);
    stalls_d = stalls_q + PERF_W'(dram_rsp_valid & is_bypass & ~dram_rsp_ready);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q  <= '0;
      stalls_q <= '0;
    end else begin
      reads_q  <= reads_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_bypass_reads  = reads_q;
  assign perf_bypass_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_bypass_rsp_router.sv
// Randomized scoreboard bench for bypass_rsp_router. A pending-read model
// predicts handshakes and pushes expected core words into per-lane queues;
// a monitor compares them whenever a lane presents a response.
module tb_bypass_rsp_router;
  import bypass_rsp_router_pkg::*;

  logic                                    clk = 1'b0;
  logic                                    reset;
  logic                                    issue_valid, issue_rw;
  logic [LANE_W-1:0]                       issue_lane;
  logic [WORD_SEL_BITS-1:0]                issue_wsel;
  logic [CORE_TAG_WIDTH-1:0]               issue_tag;
  logic                                    issue_ready;
  logic [ID_W-1:0]                         issue_id;
  logic                                    dram_rsp_valid;
  logic [LINE_BITS-1:0]                    dram_rsp_data;
  logic [DRAM_TAG_WIDTH-1:0]               dram_rsp_tag;
  logic                                    dram_rsp_ready;
  logic                                    cache_rsp_valid;
  logic [LINE_BITS-1:0]                    cache_rsp_data;
  logic [DRAM_TAG_WIDTH-1:0]               cache_rsp_tag;
  logic                                    cache_rsp_ready;
  logic [NUM_REQS-1:0]                     core_rsp_valid;
  logic [NUM_REQS-1:0][WORD_BITS-1:0]      core_rsp_data;
  logic [NUM_REQS-1:0][CORE_TAG_WIDTH-1:0] core_rsp_tag;
  logic [NUM_REQS-1:0]                     core_rsp_ready;
  logic                                    pending_empty;
  logic                                    err_unexpected;
`ifdef BYPASS_RSP_PERF_EN
  logic [PERF_W-1:0]                       perf_bypass_reads, perf_bypass_stalls;
  longint                                  m_reads, m_stalls;
`endif

  always #5 clk = ~clk;

  bypass_rsp_router dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rw(issue_rw), .issue_lane(issue_lane),
    .issue_wsel(issue_wsel), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .issue_id(issue_id),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
    .dram_rsp_tag(dram_rsp_tag), .dram_rsp_ready(dram_rsp_ready),
    .cache_rsp_valid(cache_rsp_valid), .cache_rsp_data(cache_rsp_data),
    .cache_rsp_tag(cache_rsp_tag), .cache_rsp_ready(cache_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .pending_empty(pending_empty),
`ifdef BYPASS_RSP_PERF_EN
    .perf_bypass_reads(perf_bypass_reads), .perf_bypass_stalls(perf_bypass_stalls),
`endif
    .err_unexpected(err_unexpected)
  );

  // Reference model: which ids are outstanding and where their word returns.
  typedef struct {
    logic [WORD_BITS-1:0]      data;
    logic [CORE_TAG_WIDTH-1:0] tag;
  } exp_t;

  bit   m_busy [PENDING_SIZE];
  int   m_lane [PENDING_SIZE];
  int   m_wsel [PENDING_SIZE];
  int   m_tag  [PENDING_SIZE];
  bit   m_lane_full [NUM_REQS];
  bit   m_err;
  exp_t lane_q [NUM_REQS][$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every presented core response must match the head of its lane queue.
  always @(negedge clk) begin
    if (!reset) begin
      for (int l = 0; l < NUM_REQS; l++) begin
        if (core_rsp_valid[l]) begin
          if (lane_q[l].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL core_rsp_spurious lane %0d: got valid tag %0h expected no response",
                     l, core_rsp_tag[l]);
          end else begin
            chk($sformatf("core_rsp_data[%0d]", l), 512'(core_rsp_data[l]), 512'(lane_q[l][0].data));
            chk($sformatf("core_rsp_tag[%0d]", l), 512'(core_rsp_tag[l]), 512'(lane_q[l][0].tag));
            if (core_rsp_ready[l]) begin
              $display("[TB] lane %0d rsp data %08h tag %0d", l, core_rsp_data[l], core_rsp_tag[l]);
              void'(lane_q[l].pop_front());
            end
          end
        end
      end
    end
  end

  // One clock: check combinational outputs against the model, then advance it.
  task automatic do_cycle();
    bit   full, empty, byp, hit, exp_rdy, acc_issue;
    int   fid, s, lane;
    exp_t e;
    logic [NUM_REQS-1:0] exp_cv;
    @(negedge clk);
    full = 1'b1; empty = 1'b1; fid = 0;
    for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
      if (!m_busy[i]) begin full = 1'b0; fid = i; end
      else empty = 1'b0;
    end
    byp  = dram_rsp_tag[DRAM_TAG_WIDTH-1];
    s    = int'(dram_rsp_tag[ID_W-1:0]);
    hit  = m_busy[s];
    lane = m_lane[s];
    if (!byp)     exp_rdy = cache_rsp_ready;
    else if (hit) exp_rdy = !m_lane_full[lane] || core_rsp_ready[lane];
    else          exp_rdy = 1'b1;
    acc_issue = issue_valid && (!full || issue_rw);
    for (int l = 0; l < NUM_REQS; l++) exp_cv[l] = m_lane_full[l];
    if (!reset) begin
      chk("issue_ready", 512'(issue_ready), 512'(!full || issue_rw));
      if (!full) chk("issue_id", 512'(issue_id), 512'(fid));
      chk("pending_empty", 512'(pending_empty), 512'(empty));
      chk("cache_rsp_valid", 512'(cache_rsp_valid), 512'(dram_rsp_valid && !byp));
      chk("core_rsp_valid", 512'(core_rsp_valid), 512'(exp_cv));
      chk("err_unexpected", 512'(err_unexpected), 512'(m_err));
      if (dram_rsp_valid) chk("dram_rsp_ready", 512'(dram_rsp_ready), 512'(exp_rdy));
      if (dram_rsp_valid && !byp) begin
        chk("cache_rsp_data", cache_rsp_data, dram_rsp_data);
        chk("cache_rsp_tag", 512'(cache_rsp_tag), 512'(dram_rsp_tag));
      end
`ifdef BYPASS_RSP_PERF_EN
      chk("perf_bypass_reads", 512'(perf_bypass_reads), 512'(m_reads));
      chk("perf_bypass_stalls", 512'(perf_bypass_stalls), 512'(m_stalls));
`endif
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < PENDING_SIZE; i++) m_busy[i] = 1'b0;
      for (int l = 0; l < NUM_REQS; l++) begin
        m_lane_full[l] = 1'b0;
        lane_q[l].delete();
      end
      m_err = 1'b0;
`ifdef BYPASS_RSP_PERF_EN
      m_reads = 0; m_stalls = 0;
`endif
    end else begin
      for (int l = 0; l < NUM_REQS; l++)
        if (m_lane_full[l] && core_rsp_ready[l]) m_lane_full[l] = 1'b0;
      if (dram_rsp_valid && byp && exp_rdy) begin
        if (hit) begin
          e.data = dram_rsp_data[m_wsel[s]*WORD_BITS +: WORD_BITS];
          e.tag  = CORE_TAG_WIDTH'(m_tag[s]);
          lane_q[lane].push_back(e);
          m_lane_full[lane] = 1'b1;
          m_busy[s] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
`ifdef BYPASS_RSP_PERF_EN
      if (dram_rsp_valid && byp && !exp_rdy) m_stalls++;
      if (acc_issue && !issue_rw) m_reads++;
`endif
      if (acc_issue && !issue_rw) begin
        m_busy[fid] = 1'b1;
        m_lane[fid] = int'(issue_lane);
        m_wsel[fid] = int'(issue_wsel);
        m_tag[fid]  = int'(issue_tag);
      end
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rw = 1'b0; issue_lane = '0; issue_wsel = '0; issue_tag = '0;
    dram_rsp_valid = 1'b0; dram_rsp_tag = '0;
    cache_rsp_ready = 1'b1; core_rsp_ready = '1;
  endtask

  task automatic rand_line();
    for (int i = 0; i < WORDS_PER_LINE; i++) dram_rsp_data[i*WORD_BITS +: WORD_BITS] = $urandom;
  endtask

  task automatic set_issue_read(int lane, int wsel, int tag);
    issue_valid = 1'b1; issue_rw = 1'b0;
    issue_lane = LANE_W'(lane); issue_wsel = WORD_SEL_BITS'(wsel); issue_tag = CORE_TAG_WIDTH'(tag);
  endtask

  task automatic set_bypass_rsp(int id);
    dram_rsp_valid = 1'b1;
    dram_rsp_tag = DRAM_TAG_WIDTH'($urandom);
    dram_rsp_tag[DRAM_TAG_WIDTH-1] = 1'b1;
    dram_rsp_tag[ID_W-1:0] = ID_W'(id);
  endtask

  task automatic rand_inputs(bit allow_unexp);
    int k, pick, nb;
    int busy_ids[$];
    int free_ids[$];
    issue_valid = ($urandom_range(0, 1) == 1);
    issue_rw    = ($urandom_range(0, 3) == 0);
    issue_lane  = LANE_W'($urandom);
    issue_wsel  = WORD_SEL_BITS'($urandom);
    issue_tag   = CORE_TAG_WIDTH'($urandom);
    cache_rsp_ready = ($urandom_range(0, 3) != 0);
    core_rsp_ready  = NUM_REQS'($urandom);
    dram_rsp_valid  = 1'b0;
    rand_line();
    for (int i = 0; i < PENDING_SIZE; i++) begin
      if (m_busy[i]) busy_ids.push_back(i);
      else free_ids.push_back(i);
    end
    nb = busy_ids.size();
    k = $urandom_range(0, 7);
    if (k < 2) begin
      dram_rsp_valid = 1'b1;
      dram_rsp_tag = DRAM_TAG_WIDTH'($urandom);
      dram_rsp_tag[DRAM_TAG_WIDTH-1] = 1'b0;
    end else if (k < 7 && nb > 0) begin
      pick = busy_ids[$urandom_range(0, nb - 1)];
      set_bypass_rsp(pick);
    end else if (allow_unexp && free_ids.size() > 0) begin
      pick = free_ids[$urandom_range(0, free_ids.size() - 1)];
      set_bypass_rsp(pick);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    dram_rsp_data = '0;
    do_cycle(); do_cycle();
    reset = 1'b0;
    idle();
    do_cycle();   // reset state: empty, ready, id 0, no responses, no error

    // Single read on lane 2, word 5, tag 3, answered with 0xDEADBEEF.
    set_issue_read(2, 5, 3);
    do_cycle();
    idle();
    rand_line();
    dram_rsp_data[5*WORD_BITS +: WORD_BITS] = 32'hDEADBEEF;
    set_bypass_rsp(0);
    do_cycle();
    idle();
    do_cycle(); do_cycle();

    // Fill the table, try a fifth read, issue a write while full, free id 2.
    for (int i = 0; i < PENDING_SIZE; i++) begin
      set_issue_read(i % NUM_REQS, i, i);
      do_cycle();
    end
    set_issue_read(1, 1, 1);
    do_cycle();
    issue_rw = 1'b1;
    do_cycle();
    idle();
    rand_line();
    set_bypass_rsp(2);
    do_cycle();
    set_issue_read(3, 7, 6);
    do_cycle();
    idle();
    do_cycle();

    // Randomized traffic without unexpected responses.
    for (int c = 0; c < 1500; c++) begin
      rand_inputs(1'b0);
      do_cycle();
    end

    // Reset with reads outstanding.
    idle();
    set_issue_read(0, 2, 4);
    do_cycle();
    set_issue_read(1, 3, 5);
    do_cycle();
    idle();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    do_cycle();

    // Randomized traffic including responses for free slots.
    for (int c = 0; c < 1500; c++) begin
      rand_inputs(1'b1);
      do_cycle();
    end

    idle();
    for (int c = 0; c < 4; c++) do_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
